// File: rtl/ac97_cmd_sequencer.sv
// AC97 codec register-write sequencer: post-ready delay, fixed init writes, then volume tracking.
// Optional build macro AC97_CMD_MUTE_EN maps volume_control==0 to a muted write (16'h8000).
module ac97_cmd_sequencer #(
  parameter int          POST_READY_CYCLES = 256,
  parameter logic [15:0] PCM_OUT_GAIN      = 16'h0808
) (
  input  logic        system_clock,
  input  logic        system_reset,
  input  logic        codec_ready,
  input  logic [3:0]  volume_control,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        init_done
);
  localparam int               CNT_W    = $clog2(POST_READY_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POST_READY_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_READY, DELAY, INIT0, INIT1, INIT2, IDLE, VOL_M, VOL_H
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             vol_pending;
  logic [3:0]       vol_last;
  logic [3:0]       vol_cap;
  logic [15:0]      word_cap;
  logic             xfer;
  logic             codec_lost;
  logic             capture;

  function automatic logic [15:0] vol_map(input logic [3:0] v);
    logic [4:0] att;
    att = {~v, 1'b0};
`ifdef AC97_CMD_MUTE_EN
    if (v == 4'd0) return 16'h8000;
`endif
    return {3'b000, att, 3'b000, att};
  endfunction

  assign xfer       = cmd_valid && cmd_ready;
  assign codec_lost = (state != WAIT_READY) && !codec_ready;
  assign capture    = ((state == DELAY) && (state_nxt == INIT0)) ||
                      ((state == IDLE)  && (state_nxt == VOL_M));

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) state <= WAIT_READY;
    else              state <= state_nxt;
  end

  // Outputs decode straight from state so an async reset drops cmd_valid immediately.
  always_comb begin
    state_nxt = state;
    cmd_valid = 1'b0;
    cmd_addr  = 8'h00;
    cmd_data  = 16'h0000;
    case (state)
      WAIT_READY: if (codec_ready) state_nxt = DELAY;
      DELAY:      if (cnt == CNT_LAST) state_nxt = INIT0;
      INIT0: begin
        cmd_valid = 1'b1;
        cmd_addr  = 8'h02;
        cmd_data  = word_cap;
        if (cmd_ready) state_nxt = INIT1;
      end
      INIT1: begin
        cmd_valid = 1'b1;
        cmd_addr  = 8'h04;
        cmd_data  = word_cap;
        if (cmd_ready) state_nxt = INIT2;
      end
      INIT2: begin
        cmd_valid = 1'b1;
        cmd_addr  = 8'h18;
        cmd_data  = PCM_OUT_GAIN;
        if (cmd_ready) state_nxt = IDLE;
      end
      IDLE: if (vol_pending || (volume_control != vol_last)) state_nxt = VOL_M;
      VOL_M: begin
        cmd_valid = 1'b1;
        cmd_addr  = 8'h02;
        cmd_data  = word_cap;
        if (cmd_ready) state_nxt = VOL_H;
      end
      VOL_H: begin
        cmd_valid = 1'b1;
        cmd_addr  = 8'h04;
        cmd_data  = word_cap;
        if (cmd_ready) state_nxt = IDLE;
      end
      default: state_nxt = WAIT_READY;
    endcase
    if (codec_lost) state_nxt = WAIT_READY;
  end

  // Losing the codec overrides everything, including a transfer accepted in the same cycle.
  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      cnt         <= '0;
      vol_pending <= 1'b1;
      vol_last    <= 4'd0;
      vol_cap     <= 4'd0;
      word_cap    <= 16'h0000;
      init_done   <= 1'b0;
    end else if (codec_lost) begin
      vol_pending <= 1'b1;
      init_done   <= 1'b0;
    end else begin
      if (state == WAIT_READY) cnt <= '0;
      else if (state == DELAY) cnt <= cnt + CNT_W'(1);
      if (capture) begin
        vol_cap  <= volume_control;
        word_cap <= vol_map(volume_control);
      end
      if ((state == INIT2) && xfer) begin
        init_done   <= 1'b1;
        vol_pending <= 1'b0;
        vol_last    <= vol_cap;
      end
      if ((state == VOL_H) && xfer) vol_last <= vol_cap;
    end
  end
endmodule

// File: tb/tb_ac97_cmd_sequencer.sv
// Directed bench for ac97_cmd_sequencer: init timing, volume tracking, stalls, coalescing, codec loss.
module tb_ac97_cmd_sequencer;
  logic        system_clock   = 1'b0;
  logic        system_reset   = 1'b1;
  logic        codec_ready    = 1'b0;
  logic        cmd_ready      = 1'b0;
  logic [3:0]  volume_control = 4'd15;
  logic        cmd_valid;
  logic        init_done;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;

  int          vectors     = 0;
  int          miscompares = 0;
  int          pc          = 0;
  int          at;
  int          ready_pc;
  logic [23:0] xq[$];
  logic [15:0] zero_word;

  always #5 system_clock = ~system_clock;

  ac97_cmd_sequencer dut (
    .system_clock  (system_clock),
    .system_reset  (system_reset),
    .codec_ready   (codec_ready),
    .volume_control(volume_control),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .init_done     (init_done)
  );

  always @(posedge system_clock) pc <= system_reset ? 0 : pc + 1;

  // Log every accepted command as {addr, data}.
  always @(negedge system_clock)
    if (!system_reset && cmd_valid && cmd_ready) xq.push_back({cmd_addr, cmd_data});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge system_clock);
    #1;
  endtask

  task automatic pop_cmd(input string tag, input logic [7:0] a, input logic [15:0] d);
    logic [23:0] x;
    chk({tag, "_present"}, 32'(xq.size() != 0), 32'd1);
    if (xq.size() != 0) begin
      x = xq.pop_front();
      chk(tag, {8'h00, x}, {8'h00, a, d});
    end
  endtask

  task automatic wait_valid(input int limit, output int found);
    found = -1;
    for (int i = 0; i < limit && found < 0; i++) begin
      @(negedge system_clock);
      if (cmd_valid) found = pc;
    end
  endtask

  initial begin
`ifdef AC97_CMD_MUTE_EN
    zero_word = 16'h8000;
`else
    zero_word = 16'h1E1E;
`endif
    // Reset state
    step(3);
    @(negedge system_clock);
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_addr",  {24'd0, cmd_addr},  32'd0);
    chk("rst_data",  {16'd0, cmd_data},  32'd0);
    chk("rst_init",  {31'd0, init_done}, 32'd0);
    @(posedge system_clock); #1;
    system_reset = 1'b0;

    // Init with volume 15; codec_ready first sampled on edge 10
    while (pc != 9) step(1);
    codec_ready = 1'b1;
    cmd_ready   = 1'b1;
    wait_valid(400, at);
    chk("first_valid_cycle", 32'(at), 32'd266);
    @(negedge system_clock);
    @(negedge system_clock);
    chk("init_done_before", {31'd0, init_done}, 32'd0);
    @(negedge system_clock);
    chk("init_done_after", {31'd0, init_done}, 32'd1);
    pop_cmd("init0", 8'h02, 16'h0000);
    pop_cmd("init1", 8'h04, 16'h0000);
    pop_cmd("init2", 8'h18, 16'h0808);
    @(posedge system_clock); #1;
    step(10);
    chk("idle_quiet", 32'(xq.size()), 32'd0);

    // Runtime volume writes
    volume_control = 4'd4;
    step(10);
    pop_cmd("vol4_m", 8'h02, 16'h1616);
    pop_cmd("vol4_h", 8'h04, 16'h1616);
    step(20);
    chk("vol4_quiet", 32'(xq.size()), 32'd0);
    volume_control = 4'd15;
    step(10);
    pop_cmd("vol15_m", 8'h02, 16'h0000);
    pop_cmd("vol15_h", 8'h04, 16'h0000);

    // Coalescing: 4 -> 9 -> 2 while VOL_M is stalled
    cmd_ready = 1'b0;
    volume_control = 4'd4;
    step(2);
    volume_control = 4'd9;
    step(1);
    volume_control = 4'd2;
    step(3);
    @(negedge system_clock);
    chk("stall_volm", {7'd0, cmd_valid, cmd_addr, cmd_data}, {7'd0, 1'b1, 8'h02, 16'h1616});
    @(posedge system_clock); #1;
    cmd_ready = 1'b1;
    step(12);
    pop_cmd("coal_a_m", 8'h02, 16'h1616);
    pop_cmd("coal_a_h", 8'h04, 16'h1616);
    pop_cmd("coal_b_m", 8'h02, 16'h1A1A);
    pop_cmd("coal_b_h", 8'h04, 16'h1A1A);
    step(10);
    chk("coal_quiet", 32'(xq.size()), 32'd0);

    // Codec loss during VOL_H
    cmd_ready = 1'b0;
    volume_control = 4'd15;
    step(3);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready   = 1'b0;
    codec_ready = 1'b0;
    step(1);
    @(negedge system_clock);
    chk("loss_valid", {31'd0, cmd_valid}, 32'd0);
    chk("loss_init",  {31'd0, init_done}, 32'd0);
    pop_cmd("loss_volm", 8'h02, 16'h0000);
    codec_ready = 1'b1;
    ready_pc = pc + 1;
    wait_valid(400, at);
    chk("revalid_delay", 32'(at - ready_pc), 32'd256);
    chk("reinit0_hold", {cmd_addr, cmd_data}, {8'h00, 8'h02, 16'h0000});
    chk("loss_no_extra", 32'(xq.size()), 32'd0);

    // Stall in INIT1 for 20 cycles while volume moves 15 -> 7
    @(posedge system_clock); #1;
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge system_clock);
      chk("init1_hold", {7'd0, cmd_valid, cmd_addr, cmd_data}, {7'd0, 1'b1, 8'h04, 16'h0000});
      if (i == 5) volume_control = 4'd7;
    end
    @(posedge system_clock); #1;
    cmd_ready = 1'b1;
    step(10);
    pop_cmd("re_init0", 8'h02, 16'h0000);
    pop_cmd("re_init1", 8'h04, 16'h0000);
    pop_cmd("re_init2", 8'h18, 16'h0808);
    pop_cmd("vol7_m",   8'h02, 16'h1010);
    pop_cmd("vol7_h",   8'h04, 16'h1010);
    chk("re_init_done", {31'd0, init_done}, 32'd1);
    step(10);
    chk("vol7_quiet", 32'(xq.size()), 32'd0);

    // Volume 0: mute word with the macro, full attenuation without
    volume_control = 4'd0;
    step(10);
    pop_cmd("vol0_m", 8'h02, zero_word);
    pop_cmd("vol0_h", 8'h04, zero_word);
    step(10);
    chk("vol0_quiet", 32'(xq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
